// File: rtl/ray_gen_if.sv
// Ray stream bundle between the ray generator and the intersection checker.
// valid/ready: a beat transfers on any clock edge where tvalid and tready are both high;
// once tvalid rises, tdata, hcount, vcount and select_objs hold and tvalid stays high until that transfer.
interface ray_gen_if #(
    parameter int SIZE = 32
) ();
    logic [3*SIZE-1:0] ray_axis_tdata;
    logic              ray_axis_tvalid;
    logic              ray_axis_tready;
    logic [1:0]        select_objs;
    logic [10:0]       hcount_axis_tdata;
    logic [9:0]        vcount_axis_tdata;

    modport master (
        output ray_axis_tdata, ray_axis_tvalid, select_objs,
               hcount_axis_tdata, vcount_axis_tdata,
        input  ray_axis_tready
    );

    modport slave (
        input  ray_axis_tdata, ray_axis_tvalid, select_objs,
               hcount_axis_tdata, vcount_axis_tdata,
        output ray_axis_tready
    );
endinterface

// File: rtl/ray_gen.sv
// Raster-order camera ray source: one float (x,y,z) direction per pixel of the active frame.
// Direction is (h - H/2, V/2 - v, -FOCAL), converted exactly to IEEE-754 single precision.
module ray_gen #(
    parameter int SIZE     = 32,
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 180,
    parameter int FOCAL    = 256
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic [1:0]    select_objs_in,
    ray_gen_if.master     ray,
    output logic          busy,
    output logic          frame_done,
    output logic          dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic signed [12:0] H_HALF = 13'(H_ACTIVE / 2);
    localparam logic signed [12:0] V_HALF = 13'(V_ACTIVE / 2);
    localparam logic signed [12:0] Z_VAL  = -13'(FOCAL);
    localparam logic [10:0]        H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]         V_LAST = 10'(V_ACTIVE - 1);

    // Exact for |val| < 2^12: mantissa never has more bits than fit, so no rounding.
    function automatic logic [31:0] to_float(input logic signed [12:0] val);
        logic [11:0] mag;
        logic [3:0]  msb;
        logic [23:0] shifted;
        to_float = 32'h0;
        mag      = val[12] ? 12'(-val) : val[11:0];
        msb      = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (mag[i]) msb = 4'(i);
        end
        shifted = {12'd0, mag} << (5'd23 - {1'b0, msb});
        if (mag != 12'd0) to_float = {val[12], 8'd127 + {4'd0, msb}, shifted[22:0]};
    endfunction

    state_t              state_q, state_d;
    logic [10:0]         h_q, h_d;
    logic [9:0]          v_q, v_d;
    logic [3*SIZE-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic [1:0]          sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load;
    logic                hs;
    logic signed [12:0]  x_next, y_next;

    assign hs = tvalid_q & ray.ray_axis_tready;

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        tvalid_d = tvalid_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    h_d      = 11'd0;
                    v_d      = 10'd0;
                    sel_d    = select_objs_in;
                    tvalid_d = 1'b1;
                    busy_d   = 1'b1;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (hs) begin
                    if (h_q != H_LAST) begin
                        h_d  = h_q + 11'd1;
                        load = 1'b1;
                    end else if (v_q != V_LAST) begin
                        h_d  = 11'd0;
                        v_d  = v_q + 10'd1;
                        load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Floats come from the next counter values so they land on the same edge as the counters.
    assign x_next  = $signed({2'b00, h_d}) - H_HALF;
    assign y_next  = V_HALF - $signed({3'b000, v_d});
    assign tdata_d = load ? {to_float(x_next), to_float(y_next), to_float(Z_VAL)} : tdata_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            h_q      <= 11'd0;
            v_q      <= 10'd0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            sel_q    <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ray.ray_axis_tdata    = tdata_q;
    assign ray.ray_axis_tvalid   = tvalid_q;
    assign ray.select_objs       = sel_q;
    assign ray.hcount_axis_tdata = h_q;
    assign ray.vcount_axis_tdata = v_q;
    assign busy                  = busy_q;
    assign frame_done            = done_q;
    assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_ray_gen.sv
// Bench for ray_gen: a 4x2 instance for protocol scenarios and a default 320x180 instance.
// Beat layout: {tvalid, select_objs, hcount, vcount, x, y, z}.
module tb_ray_gen;
    localparam int W = 120;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start_s = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] sel_in = 2'b00;
    logic       tready = 1'b0;
    logic       use_big = 1'b0;
    logic       busy_s, busy_b, done_s, done_b, dbg_s, dbg_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    always #5 aclk = ~aclk;

    ray_gen_if #(.SIZE(32)) if_s ();
    ray_gen_if #(.SIZE(32)) if_b ();
    assign if_s.ray_axis_tready = tready;
    assign if_b.ray_axis_tready = tready;

    ray_gen #(.SIZE(32), .H_ACTIVE(4), .V_ACTIVE(2), .FOCAL(256)) u_small (
        .aclk(aclk), .aresetn(aresetn), .start(start_s), .select_objs_in(sel_in),
        .ray(if_s), .busy(busy_s), .frame_done(done_s), .dbg_state_o(dbg_s)
    );

    ray_gen u_big (
        .aclk(aclk), .aresetn(aresetn), .start(start_b), .select_objs_in(sel_in),
        .ray(if_b), .busy(busy_b), .frame_done(done_b), .dbg_state_o(dbg_b)
    );

    logic [W-1:0] m_cur;
    logic         m_tvalid, m_busy, m_done, m_dbg;
    assign m_cur = use_big ?
        {if_b.ray_axis_tvalid, if_b.select_objs, if_b.hcount_axis_tdata, if_b.vcount_axis_tdata, if_b.ray_axis_tdata} :
        {if_s.ray_axis_tvalid, if_s.select_objs, if_s.hcount_axis_tdata, if_s.vcount_axis_tdata, if_s.ray_axis_tdata};
    assign m_tvalid = m_cur[119];
    assign m_busy   = use_big ? busy_b : busy_s;
    assign m_done   = use_big ? done_b : done_s;
    assign m_dbg    = use_big ? dbg_b : dbg_s;

    // Reference conversion goes through the simulator's double representation.
    function automatic logic [31:0] int2f(input int v);
        real         r;
        logic [63:0] d;
        if (v == 0) return 32'h0;
        r = v;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [W-1:0] pack_beat(input int h, input int v, input int ha, input int va,
                                               input logic [1:0] sel);
        return {1'b1, sel, 11'(h), 10'(v), int2f(h - ha / 2), int2f(va / 2 - v), int2f(-256)};
    endfunction

    task automatic fill_exp(input int ha, input int va, input logic [1:0] sel);
        for (int v = 0; v < va; v++)
            for (int h = 0; h < ha; h++)
                exp_q.push_back(pack_beat(h, v, ha, va, sel));
    endtask

    task automatic set_start(input logic val);
        if (use_big) start_b = val;
        else start_s = val;
    endtask

    // Leaves the caller on the negedge where start is already low and the first beat is visible.
    task automatic pulse_start(input logic [1:0] sel);
        @(negedge aclk);
        sel_in = sel;
        set_start(1'b1);
        @(negedge aclk);
        set_start(1'b0);
    endtask

    // Returns on the negedge that presented the last wanted handshake.
    task automatic drain(input bit rnd, input int budget, input int max_hs, input bit poke_start,
                         output int nhs, output int cycles);
        logic [W-1:0] prev, exp;
        bit           stalled;
        nhs     = 0;
        stalled = 0;
        prev    = '0;
        got_q.delete();
        for (cycles = 0; cycles < budget; cycles++) begin
            if (stalled) begin
                n_checks++;
                if (m_cur !== prev) begin
                    n_errors++;
                    $display("FAIL hold: got %h required %h", m_cur, prev);
                end
            end
            set_start(poke_start && cycles == 3);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_tvalid && tready) begin
                exp = exp_q.pop_front();
                got_q.push_back(m_cur);
                n_checks++;
                if (m_cur !== exp) begin
                    n_errors++;
                    $display("FAIL beat %0d: got %h required %h", nhs, m_cur, exp);
                end
                nhs++;
                stalled = 0;
                if (nhs == max_hs) begin
                    cycles++;
                    break;
                end
            end else begin
                stalled = m_tvalid;
            end
            prev = m_cur;
            @(negedge aclk);
        end
        set_start(1'b0);
        n_checks++;
        if (nhs != max_hs) begin
            n_errors++;
            $display("FAIL handshake_count: got %0d required %0d", nhs, max_hs);
        end
    endtask

    task automatic check_done(input bit start_next);
        @(negedge aclk);
        tready = 1'b0;
        n_checks++;
        if ({m_done, m_busy, m_tvalid} !== 3'b100) begin
            n_errors++;
            $display("FAIL done_cycle: got done/busy/valid %b required 100", {m_done, m_busy, m_tvalid});
        end
        if (start_next) set_start(1'b1);
        @(negedge aclk);
        set_start(1'b0);
        n_checks++;
        if (m_done !== 1'b0) begin
            n_errors++;
            $display("FAIL done_width: got %b required 0", m_done);
        end
        if (start_next) begin
            n_checks++;
            if ({m_tvalid, m_busy, m_cur[116:96]} !== {2'b11, 21'd0}) begin
                n_errors++;
                $display("FAIL restart: got valid/busy/h/v %b %b %0d %0d required 1 1 0 0",
                         m_tvalid, m_busy, m_cur[116:106], m_cur[105:96]);
            end
        end
    endtask

    task automatic test_reset();
        for (int b = 0; b < 2; b++) begin
            use_big = 1'(b);
            #1;
            n_checks++;
            if ({m_cur, m_busy, m_done, m_dbg} !== '0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: got %h %b%b%b required 0", b, m_cur, m_busy, m_done, m_dbg);
            end
        end
        use_big = 1'b0;
    endtask

    task automatic test_small_basic();
        int nhs, cyc;
        fill_exp(4, 2, 2'b00);
        pulse_start(2'b00);
        n_checks++;
        if ({m_tvalid, m_busy, m_dbg} !== 3'b111) begin
            n_errors++;
            $display("FAIL first_valid_latency: got valid/busy/state %b required 111", {m_tvalid, m_busy, m_dbg});
        end
        n_checks++;
        if (m_cur[95:0] !== {32'hC0000000, 32'h3F800000, 32'hC3800000}) begin
            n_errors++;
            $display("FAIL beat0_floats: got %h required c00000003f800000c3800000", m_cur[95:0]);
        end
        drain(0, 50, 8, 0, nhs, cyc);
        n_checks++;
        if (cyc != 8) begin
            n_errors++;
            $display("FAIL no_bubbles: got %0d cycles required 8", cyc);
        end
        if (got_q.size() == 8) begin
            n_checks++;
            if (got_q[2][95:64] !== 32'h0) begin
                n_errors++;
                $display("FAIL beat2_x: got %h required 00000000", got_q[2][95:64]);
            end
            n_checks++;
            if (got_q[7][95:32] !== {32'h3F800000, 32'h0}) begin
                n_errors++;
                $display("FAIL beat7_xy: got %h required 3f80000000000000", got_q[7][95:32]);
            end
        end
        check_done(0);
    endtask

    task automatic test_backpressure();
        int nhs, cyc;
        fill_exp(4, 2, 2'b00);
        pulse_start(2'b00);
        drain(1, 300, 8, 0, nhs, cyc);
        check_done(0);
    endtask

    task automatic test_select_latch();
        int nhs, cyc;
        fill_exp(4, 2, 2'b10);
        pulse_start(2'b10);
        sel_in = 2'b01;
        drain(1, 300, 8, 0, nhs, cyc);
        check_done(0);
    endtask

    task automatic test_back_to_back();
        int nhs, cyc;
        fill_exp(4, 2, 2'b11);
        pulse_start(2'b11);
        drain(0, 50, 8, 1, nhs, cyc);
        fill_exp(4, 2, 2'b11);
        check_done(1);
        drain(1, 300, 8, 0, nhs, cyc);
        check_done(0);
    endtask

    task automatic test_reset_mid();
        int nhs, cyc;
        fill_exp(4, 2, 2'b01);
        pulse_start(2'b01);
        drain(0, 50, 3, 0, nhs, cyc);
        exp_q.delete();
        @(negedge aclk);
        tready = 1'b0;
        n_checks++;
        if (m_cur[116:106] !== 11'd3) begin
            n_errors++;
            $display("FAIL beat3_h: got %0d required 3", m_cur[116:106]);
        end
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({m_cur, m_busy, m_done, m_dbg} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got %h %b%b%b required 0", m_cur, m_busy, m_done, m_dbg);
        end
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_checks++;
            if (m_done !== 1'b0) begin
                n_errors++;
                $display("FAIL spurious_done: got %b required 0", m_done);
            end
        end
        fill_exp(4, 2, 2'b01);
        pulse_start(2'b01);
        drain(1, 300, 8, 0, nhs, cyc);
        check_done(0);
    endtask

    task automatic test_default_frame();
        int nhs, cyc;
        use_big = 1'b1;
        fill_exp(320, 180, 2'b11);
        pulse_start(2'b11);
        drain(0, 60000, 57600, 0, nhs, cyc);
        if (got_q.size() == 57600) begin
            n_checks++;
            if (got_q[0][95:32] !== {32'hC3200000, 32'h42B40000}) begin
                n_errors++;
                $display("FAIL big_beat0: got %h required c320000042b40000", got_q[0][95:32]);
            end
            n_checks++;
            if (got_q[163][95:64] !== 32'h40400000) begin
                n_errors++;
                $display("FAIL big_h163_x: got %h required 40400000", got_q[163][95:64]);
            end
            n_checks++;
            if (got_q[57599][95:32] !== {32'h431F0000, 32'hC2B20000}) begin
                n_errors++;
                $display("FAIL big_last: got %h required 431f0000c2b20000", got_q[57599][95:32]);
            end
        end
        check_done(0);
        use_big = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        test_reset();
        aresetn = 1'b1;
        test_small_basic();
        test_backpressure();
        test_select_latch();
        test_back_to_back();
        test_reset_mid();
        test_default_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
